puf_key_reader: RTL
===================

# puf_key_reader

Reader-side controller for the 64-bit PUF response generator. On a `start` request it drives the generator's `enable`/`control_input` pair through a fixed number of power-up/capture cycles and majority-votes every response bit across the samples. It then presents a stable key with a valid/error status. It sits between the PUF generator and the key-consuming logic (key store / crypto core) of the root-of-trust.

## Interface
- `WIDTH`, 64: response/key width; must match the generator output width.
- `NUM_SAMPLES`, 7: responses captured per request; odd, 3..15.
- `SETTLE_CYCLES`, 4: cycles `puf_enable` is high before each capture; ≥1.
- `OFF_CYCLES`, 2: cycles `puf_enable` is low between captures; ≥1.
- `MAX_UNSTABLE`, 8: highest non-unanimous bit count that still yields a valid key.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `challenge`  in  2  control value for the generator; latched on accept.
- `puf_enable`  out  1  to generator `enable`.
- `puf_control`  out  2  to generator `control_input`.
- `puf_response`  in  WIDTH  from generator `output_signal`.
- `busy`  out  1  high from accept until the result is presented.
- `done`  out  1  one-cycle pulse when the result is presented.
- `key`  out  WIDTH  majority-voted key.
- `key_valid`  out  1  level; the key is usable.
- `key_error`  out  1  level; too many unstable bits.
- `unstable_count`  out  $clog2(WIDTH+1)  number of bits not unanimous across the samples.

## Operation
- FSM states: IDLE, ON, OFF, EVAL, DONE.
- **IDLE**
  - `start=1` latches `challenge` into `puf_control`.
  - Clears `key_valid`, `key_error`, `key`, `unstable_count` and all per-bit ones-counters.
  - Next state is ON.
- **ON**
  - `puf_enable=1` for `SETTLE_CYCLES` cycles.
  - On the last ON cycle, each bit's ones-counter (width $clog2(NUM_SAMPLES+1)) increments when `puf_response[i]=1`, and the sample counter increments.
  - Next state is OFF.
- **OFF**
  - `puf_enable=0` for `OFF_CYCLES` cycles.
  - Next state is ON if samples < `NUM_SAMPLES`, otherwise EVAL.
- **EVAL** (1 cycle)
  - `key[i] = (ones[i] > NUM_SAMPLES/2)`.
  - Bit i is unstable when `ones[i]` is neither 0 nor `NUM_SAMPLES`.
  - `unstable_count` is the popcount of unstable bits.
- **DONE** (1 cycle)
  - `done=1`, `busy=0`.
  - `key_valid = (unstable_count <= MAX_UNSTABLE)`, `key_error = !key_valid`.
  - Returns to IDLE.
- In IDLE, `key`, `key_valid`, `key_error` and `unstable_count` hold until the next accepted `start`.
- `start` while `busy` is ignored; it is neither queued nor restarts the sequence.
- `puf_control` holds the latched challenge from accept until the next accept; `challenge` changes mid-operation have no effect.
- When the key is in error, `key` still shows the voted value; consumers gate on `key_valid`.

## Timing
- **Reset values:** every output is 0; FSM in IDLE; all counters 0.
- **Accept:** `start` sampled high at edge k.
  - `busy=1` and `puf_enable=1` from cycle k+1.
  - Capture of sample j (j=0..N-1) is on the edge ending cycle k+j·(S+F)+S.
- **Result:** `done`, `key_valid`/`key_error` and `key` are visible at cycle k+N·(S+F)+2.
  - With defaults (N=7, S=4, F=2) this is cycle k+44.
  - `busy` is low at the same cycle.
  - Back-to-back: a new `start` is accepted at the earliest in the cycle after `done`.
- **`start` in the DONE cycle:** ignored.
- **`rst` mid-operation:**
  - FSM returns to IDLE, and `puf_enable`=0 on the following cycle.
  - `key`/status are cleared; no `done` pulse.
- **Counter bounds:** counters never exceed `NUM_SAMPLES`, so there is no wrap.
  - `unstable_count` maximum is `WIDTH` (64 needs 7 bits).

## Test plan
1. Constant response 64'hDEADBEEF_01234567 with challenge 2'b10 → at k+44: `key`=64'hDEADBEEF_01234567, `unstable_count`=0, `key_valid`=1, `done` pulsed once; `puf_control`=2'b10 throughout.
2. Bit 0 forced to 1 in samples 1, 3 and 5 of base 64'h0 → `key`=64'h0, `unstable_count`=1, `key_valid`=1. Bit 63 forced to 1 in 4 of 7 samples → `key[63]`=1.
3. Nine bits toggling every sample → `unstable_count`=9, `key_error`=1, `key_valid`=0.
4. Exactly 8 toggling bits → `key_valid`=1 (threshold boundary).
5. `start` re-pulsed at k+10 and `challenge` changed at k+5 → completes once at k+44; `puf_control` unchanged; no second run.
6. `rst` at k+20 → `puf_enable`=0 at k+21, all outputs 0, no `done`; a fresh `start` then completes normally 44 cycles later.
7. Check `puf_enable` high/low cycle counts equal `SETTLE_CYCLES`/`OFF_CYCLES` per sample.

Source files
------------

// File: rtl/puf_key_reader.sv
// Reader-side controller for a PUF response generator: power-cycles the generator,
// captures NUM_SAMPLES responses, majority-votes each bit and reports key stability.
module puf_key_reader #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned NUM_SAMPLES   = 7,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned OFF_CYCLES    = 2,
  parameter int unsigned MAX_UNSTABLE  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [1:0]                   i_challenge,
  output logic                         o_puf_enable,
  output logic [1:0]                   o_puf_control,
  input  logic [WIDTH-1:0]             i_puf_response,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [WIDTH-1:0]             o_key,
  output logic                         o_key_valid,
  output logic                         o_key_error,
  output logic [$clog2(WIDTH+1)-1:0]   o_unstable_count
);

  localparam int unsigned CW    = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned UW    = $clog2(WIDTH + 1);
  localparam int unsigned MaxPh = (SETTLE_CYCLES > OFF_CYCLES) ? SETTLE_CYCLES : OFF_CYCLES;
  localparam int unsigned PW    = $clog2(MaxPh + 1);

  localparam logic [CW-1:0] Full = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0] Half = CW'(NUM_SAMPLES / 2);

  typedef enum logic [2:0] {StIdle, StOn, StOff, StEval, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [PW-1:0]   r_phase;
  logic [CW-1:0]   r_samples;
  logic [CW-1:0]   r_ones [WIDTH];
  logic [1:0]      r_ctrl;
  logic [WIDTH-1:0] r_key;
  logic            r_valid;
  logic            r_error;
  logic [UW-1:0]   r_ucnt;

  logic            w_on_last;
  logic            w_off_last;
  logic [WIDTH-1:0] w_key;
  logic [WIDTH-1:0] w_unstable;
  logic [UW-1:0]   w_ucnt;
  logic            w_valid;

  assign w_on_last  = (r_state == StOn)  && (r_phase == PW'(SETTLE_CYCLES - 1));
  assign w_off_last = (r_state == StOff) && (r_phase == PW'(OFF_CYCLES - 1));

  // Vote and stability evaluation over the accumulated ones-counters.
  always_comb begin
    w_key      = '0;
    w_unstable = '0;
    w_ucnt     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_key[i]      = (r_ones[i] > Half);
      w_unstable[i] = (r_ones[i] != '0) && (r_ones[i] != Full);
      w_ucnt        = w_ucnt + UW'(w_unstable[i]);
    end
    w_valid = (32'(w_ucnt) <= MAX_UNSTABLE);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StOn;
      StOn:    if (w_on_last) w_state_next = StOff;
      StOff:   if (w_off_last) w_state_next = (r_samples < Full) ? StOn : StEval;
      StEval:  w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_puf_enable = (r_state == StOn);
    o_busy       = (r_state == StOn) || (r_state == StOff) || (r_state == StEval);
    o_done       = (r_state == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_samples <= '0;
      r_ctrl    <= '0;
      r_key     <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_ucnt    <= '0;
      for (int i = 0; i < WIDTH; i++) r_ones[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_ctrl    <= i_challenge;
            r_key     <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_ucnt    <= '0;
            r_phase   <= '0;
            r_samples <= '0;
            for (int i = 0; i < WIDTH; i++) r_ones[i] <= '0;
          end
        end
        StOn: begin
          if (w_on_last) begin
            r_phase   <= '0;
            r_samples <= r_samples + CW'(1);
            for (int i = 0; i < WIDTH; i++) begin
              if (i_puf_response[i]) r_ones[i] <= r_ones[i] + CW'(1);
            end
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        StOff: begin
          r_phase <= w_off_last ? '0 : r_phase + PW'(1);
        end
        StEval: begin
          // Status is registered together with the key so all appear in the DONE cycle.
          r_key   <= w_key;
          r_ucnt  <= w_ucnt;
          r_valid <= w_valid;
          r_error <= !w_valid;
        end
        default: ;
      endcase
    end
  end

  assign o_puf_control    = r_ctrl;
  assign o_key            = r_key;
  assign o_key_valid      = r_valid;
  assign o_key_error      = r_error;
  assign o_unstable_count = r_ucnt;

endmodule
